// File: rtl/pipelined_select_adder_if.sv
// Operand/result handshake bundle for pipelined_select_adder.
// The master side issues operands and consumes results; the slave side is the adder.
interface pipelined_select_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             c_out;
  logic             c_in_msb;
  logic             overflow;

  modport master (
    output in_valid, a, b, sub, c_in, out_ready,
    input  in_ready, out_valid, s, c_out, c_in_msb, overflow
  );

  modport slave (
    input  in_valid, a, b, sub, c_in, out_ready,
    output in_ready, out_valid, s, c_out, c_in_msb, overflow
  );
endinterface

// File: rtl/pipelined_select_adder.sv
// WIDTH-bit carry-select adder/subtractor split into STAGES segment-wide pipeline stages
// behind a global-stall valid/ready handshake. Define PSA_SATURATE_EN to clamp s on overflow.
module pipelined_select_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input logic                     clock,
  input logic                     reset,
  pipelined_select_adder_if.slave bus
);
  localparam int SEG = WIDTH / STAGES;

  logic             adv;
  logic [WIDTH-1:0] bx;
  logic             cx;

  assign bx           = bus.sub ? ~bus.b : bus.b;
  assign cx           = bus.sub | bus.c_in;
  assign adv          = !g_stage[STAGES-1].valid_q || bus.out_ready;
  assign bus.in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int HI  = (k + 1) * SEG;  // result bits resolved once this stage is loaded
    localparam int SRC = WIDTH - k * SEG; // operand bits still unresolved on entry

    logic [SRC-1:0] src_a;
    logic [SRC-1:0] src_b;
    logic           src_c;
    logic           src_v;
    logic [SEG:0]   sum_c0;
    logic [SEG:0]   sum_c1;
    logic [SEG:0]   sum_sel;
    logic [HI-1:0]  res_wrap;
    logic [HI-1:0]  res_d;
    logic [HI-1:0]  res_q;
    logic           valid_q;
    logic           carry_q;

    if (k == 0) begin : g_head
      assign src_a    = bus.a;
      assign src_b    = bx;
      assign src_c    = cx;
      assign src_v    = bus.in_valid;
      assign res_wrap = sum_sel[SEG-1:0];
    end else begin : g_body
      assign src_a    = g_stage[k-1].g_skew.a_sk_q;
      assign src_b    = g_stage[k-1].g_skew.b_sk_q;
      assign src_c    = g_stage[k-1].carry_q;
      assign src_v    = g_stage[k-1].valid_q;
      assign res_wrap = {sum_sel[SEG-1:0], g_stage[k-1].res_q};
    end

    // Both candidate sums are ready before the previous segment's carry arrives.
    assign sum_c0  = {1'b0, src_a[SEG-1:0]} + {1'b0, src_b[SEG-1:0]};
    assign sum_c1  = {1'b0, src_a[SEG-1:0]} + {1'b0, src_b[SEG-1:0]} + {{SEG{1'b0}}, 1'b1};
    assign sum_sel = src_c ? sum_c1 : sum_c0;

    if (k < STAGES - 1) begin : g_skew
      logic [SRC-SEG-1:0] a_sk_q;
      logic [SRC-SEG-1:0] b_sk_q;

      assign res_d = res_wrap;

      always_ff @(posedge clock) begin
        if (reset) begin
          a_sk_q <= '0;
          b_sk_q <= '0;
        end else if (adv) begin
          a_sk_q <= src_a[SRC-1:SEG];
          b_sk_q <= src_b[SRC-1:SEG];
        end
      end
    end else begin : g_tail
      logic cmsb_d;
      logic cmsb_q;

      // Carry into the top bit, recovered from the top bit's own sum equation.
      assign cmsb_d = src_a[SEG-1] ^ src_b[SEG-1] ^ sum_sel[SEG-1];

`ifdef PSA_SATURATE_EN
      assign res_d = (sum_sel[SEG] ^ cmsb_d)
                   ? {src_a[SEG-1], {(WIDTH-1){~src_a[SEG-1]}}}
                   : res_wrap;
`else
      assign res_d = res_wrap;
`endif

      always_ff @(posedge clock) begin
        if (reset)
          cmsb_q <= 1'b0;
        else if (adv)
          cmsb_q <= cmsb_d;
      end
    end

    // NOTE: every register uses <= so each stage samples its neighbour's pre-edge value;
    // data is cleared on reset too, so s reads 0 rather than a stale sum.
    always_ff @(posedge clock) begin
      if (reset) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        res_q   <= '0;
      end else if (adv) begin
        valid_q <= src_v;
        carry_q <= sum_sel[SEG];
        res_q   <= res_d;
      end
    end
  end

  assign bus.out_valid = g_stage[STAGES-1].valid_q;
  assign bus.s         = g_stage[STAGES-1].res_q;
  assign bus.c_out     = g_stage[STAGES-1].carry_q;
  assign bus.c_in_msb  = g_stage[STAGES-1].g_tail.cmsb_q;
  assign bus.overflow  = g_stage[STAGES-1].carry_q ^ g_stage[STAGES-1].g_tail.cmsb_q;
endmodule
